round_ctrl: RTL and testbench

ROUND_CTRL -- requirements
Module: round_ctrl

---
 rtl/round_ctrl_pkg.sv | 18 +
 rtl/round_ctrl_win_timer.sv | 23 ++
 rtl/round_ctrl.sv | 136 +++++++++++++
 tb/tb_round_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the reaction-game round controller.
package round_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    SAMPLE,
    SHOW,
    HIT,
    MISS,
    OVER
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'd3;
  localparam logic [7:0] SCORE_MAX  = 8'd255;
  localparam logic [1:0] MAX_RETRY  = 2'd3;

endpackage

// File: rtl/round_ctrl_win_timer.sv
// Loadable, tick-enabled 11-bit down-counter with a zero flag.
module win_timer (
  input  logic        clock,
  input  logic        new_Game_n,
  input  logic        ld,
  input  logic [10:0] value,
  input  logic        en,
  output logic [10:0] count,
  output logic        zero
);

  always_ff @(posedge clock) begin
    if (!new_Game_n)
      count <= '0;
    else if (ld)
      count <= value;
    else if (en && (count != '0))
      count <= count - 11'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/round_ctrl.sv
// Round controller: draws a random target, times the response window,
// scores hits and tracks lives until the game is over.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int NUM_TGT  = 8,
  parameter int WIN_INIT = 1000,
  parameter int WIN_MIN  = 250,
  parameter int WIN_STEP = 125
) (
  input  logic               clock,
  input  logic               new_Game_n,
  input  logic               start,
  input  logic               tick,
  input  logic [NUM_TGT-1:0] hit_key,
  input  logic [5:0]         pn6,
  output logic               load,
  output logic [NUM_TGT-1:0] target_led,
  output logic [7:0]         score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [10:0]        W_INIT  = 11'(WIN_INIT);
  localparam logic [10:0]        W_MIN   = 11'(WIN_MIN);
  localparam logic [10:0]        W_STEP  = 11'(WIN_STEP);
  localparam logic [11:0]        W_FLOOR = 12'(WIN_MIN + WIN_STEP);
  localparam logic [NUM_TGT-1:0] ONE_HOT = NUM_TGT'(1);

  state_t         state, state_nxt;
  logic [10:0]    window;
  logic [IW-1:0]  prev_idx;
  logic           prev_vld;
  logic [1:0]     retry;
  logic [1:0]     hit_cnt;
  logic [IW-1:0]  cand, pick;
  logic           collide;
  logic [10:0]    tmr_cnt;
  logic           tmr_zero, tmr_ld, t_exp;
  logic           unused_pn;

  assign unused_pn = ^pn6;
  assign cand      = pn6[IW-1:0];
  assign collide   = prev_vld && (cand == prev_idx);
  // Only reached with collide set once the retries are spent.
  assign pick      = collide ? cand + IW'(1) : cand;
  assign t_exp     = tick && (tmr_zero || (tmr_cnt == 11'd1));
  assign tmr_ld    = (state == SAMPLE) && (state_nxt == SHOW);

  win_timer u_timer (
    .clock      (clock),
    .new_Game_n (new_Game_n),
    .ld         (tmr_ld),
    .value      (window),
    .en         (tick && (state == SHOW)),
    .count      (tmr_cnt),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (!new_Game_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OVER: if (start) state_nxt = DRAW;
      DRAW:       state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (collide && (retry < MAX_RETRY)) ? DRAW : SHOW;
      SHOW: begin
        if (|hit_key)   state_nxt = (hit_key == target_led) ? HIT : MISS;
        else if (t_exp) state_nxt = MISS;
      end
      HIT:        state_nxt = DRAW;
      MISS:       state_nxt = (lives == '0) ? OVER : DRAW;
      default:    state_nxt = IDLE;
    endcase
  end

  // Results are registered on the edge entering HIT/MISS so they are visible during those states.
  always_ff @(posedge clock) begin
    if (!new_Game_n) begin
      load       <= 1'b1;
      target_led <= '0;
      score      <= '0;
      lives      <= LIVES_INIT;
      game_over  <= 1'b0;
      window     <= W_INIT;
      prev_idx   <= '0;
      prev_vld   <= 1'b0;
      retry      <= '0;
      hit_cnt    <= '0;
    end else begin
      load      <= (state_nxt != DRAW);
      game_over <= (state_nxt == OVER);
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score    <= '0;
            lives    <= LIVES_INIT;
            window   <= W_INIT;
            prev_vld <= 1'b0;
            retry    <= '0;
            hit_cnt  <= '0;
          end
        end
        SAMPLE: begin
          if (state_nxt == DRAW) begin
            retry <= retry + 2'd1;
          end else begin
            retry      <= '0;
            prev_idx   <= pick;
            prev_vld   <= 1'b1;
            target_led <= ONE_HOT << pick;
          end
        end
        SHOW: begin
          if (state_nxt == HIT) begin
            target_led <= '0;
            if (score != SCORE_MAX) score <= score + 8'd1;
            hit_cnt <= hit_cnt + 2'd1;
            if (hit_cnt == 2'd3)
              window <= ({1'b0, window} >= W_FLOOR) ? window - W_STEP : W_MIN;
          end else if (state_nxt == MISS) begin
            target_led <= '0;
            lives      <= lives - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with hand-computed expectations.
module tb_round_ctrl;

  logic       clock = 1'b0;
  logic       new_Game_n = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] hit_key = '0;
  logic [5:0] pn6 = '0;
  logic       load;
  logic [7:0] target_led;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_score = 0;

  round_ctrl #(.NUM_TGT(8), .WIN_INIT(1000), .WIN_MIN(250), .WIN_STEP(125)) dut (
    .clock      (clock),
    .new_Game_n (new_Game_n),
    .start      (start),
    .tick       (tick),
    .hit_key    (hit_key),
    .pn6        (pn6),
    .load       (load),
    .target_led (target_led),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic go_show(input logic [5:0] p, input logic [7:0] tgt);
    int unsigned n = 0;
    while (load !== 1'b0 && n < 8) begin
      step();
      n++;
    end
    chk("draw_seen", load, 0);
    pn6 = p;
    step();
    chk("sample_load", load, 1);
    step();
    chk("show_tgt", target_led, tgt);
  endtask

  task automatic hit_round(input logic [5:0] p, input logic [7:0] tgt);
    go_show(p, tgt);
    hit_key = tgt;
    step();
    hit_key = '0;
    exp_score++;
    chk("hit_score", score, exp_score);
    chk("hit_tgt_clr", target_led, 0);
  endtask

  task automatic timeout_round(input logic [5:0] p, input logic [7:0] tgt,
                               input int unsigned win, input logic [1:0] exp_lives);
    go_show(p, tgt);
    tick = 1'b1;
    repeat (win - 1) step();
    chk("pre_expire_tgt", target_led, tgt);
    step();
    tick = 1'b0;
    chk("expire_tgt", target_led, 0);
    chk("expire_lives", lives, exp_lives);
  endtask

  initial begin
    int unsigned pulses;
    step();
    step();
    chk("rst_load", load, 1);
    chk("rst_tgt", target_led, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_over", game_over, 0);
    new_Game_n = 1'b1;
    step();
    chk("idle_load", load, 1);

    // Game 1: first target, hit, mixed-key miss, expiring-tick hit, lone wrong key, timeout.
    pulse_start();
    chk("draw_load_low", load, 0);
    pn6 = 6'h05;
    step();
    chk("sample_load_high", load, 1);
    chk("sample_tgt", target_led, 0);
    step();
    chk("first_tgt", target_led, 8'h20);
    hit_key = 8'h20;
    step();
    hit_key = '0;
    exp_score = 1;
    chk("hit1_score", score, 1);
    chk("hit1_tgt", target_led, 0);
    chk("hit1_lives", lives, 3);

    go_show(6'h01, 8'h02);
    pulse_start();
    chk("start_ignored", target_led, 8'h02);
    hit_key = 8'h03;
    step();
    hit_key = '0;
    chk("mix_lives", lives, 2);
    chk("mix_score", score, 1);
    chk("mix_tgt", target_led, 0);

    go_show(6'h07, 8'h80);
    for (int i = 0; i < 999; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    chk("late_tgt_lit", target_led, 8'h80);
    tick = 1'b1;
    hit_key = 8'h80;
    step();
    tick = 1'b0;
    hit_key = '0;
    exp_score = 2;
    chk("late_hit_score", score, 2);
    chk("late_hit_lives", lives, 2);

    go_show(6'h00, 8'h01);
    hit_key = 8'h10;
    step();
    hit_key = '0;
    chk("lone_lives", lives, 1);
    chk("lone_score", score, 2);

    timeout_round(6'h01, 8'h02, 1000, 2'd0);
    chk("miss_not_over", game_over, 0);
    step();
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    chk("over_score", score, 2);
    chk("over_tgt", target_led, 0);
    hit_key = 8'h02;
    tick = 1'b1;
    step();
    hit_key = '0;
    tick = 1'b0;
    chk("over_key_ign", score, 2);
    chk("over_hold", game_over, 1);

    // Game 2: three timeouts end the game.
    pulse_start();
    chk("g2_score", score, 0);
    chk("g2_lives", lives, 3);
    chk("g2_over", game_over, 0);
    timeout_round(6'h03, 8'h08, 1000, 2'd2);
    timeout_round(6'h04, 8'h10, 1000, 2'd1);
    timeout_round(6'h03, 8'h08, 1000, 2'd0);
    step();
    chk("g2_over_flag", game_over, 1);
    chk("g2_over_lives", lives, 0);

    // Game 3: collision retries, then window shrink observed through timeouts.
    pulse_start();
    exp_score = 0;
    hit_round(6'h02, 8'h04);
    pn6 = 6'h0A;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (load === 1'b0) pulses++;
      if (target_led !== 8'h00) break;
    end
    chk("retry_pulses", pulses, 4);
    chk("retry_tgt", target_led, 8'h08);
    hit_key = 8'h08;
    step();
    hit_key = '0;
    exp_score++;
    chk("retry_hit_score", score, exp_score);
    hit_round(6'h15, 8'h20);
    hit_round(6'h00, 8'h01);
    timeout_round(6'h01, 8'h02, 875, 2'd2);
    hit_round(6'h03, 8'h08);
    hit_round(6'h04, 8'h10);
    hit_round(6'h05, 8'h20);
    hit_round(6'h06, 8'h40);
    timeout_round(6'h07, 8'h80, 750, 2'd1);

    go_show(6'h00, 8'h01);
    tick = 1'b1;
    repeat (3) step();
    new_Game_n = 1'b0;
    hit_key = 8'h01;
    step();
    tick = 1'b0;
    hit_key = '0;
    chk("rs_load", load, 1);
    chk("rs_tgt", target_led, 0);
    chk("rs_score", score, 0);
    chk("rs_lives", lives, 3);
    chk("rs_over", game_over, 0);
    new_Game_n = 1'b1;
    step();
    chk("rs_idle_tgt", target_led, 0);

    pulse_start();
    chk("rd_draw", load, 0);
    new_Game_n = 1'b0;
    step();
    new_Game_n = 1'b1;
    chk("rd_load", load, 1);
    step();
    step();
    chk("rd_no_tgt", target_led, 0);
    chk("rd_still_load", load, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
